// File: rtl/fp_to_fixed_if.sv
// fp_to_fixed_if: start/data/result bus for the float-to-Q2.30 converter
interface fp_to_fixed_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        ovf;
    modport master (output clk_en, start, dataa, input result, done, ovf);
    modport slave (input clk_en, start, dataa, output result, done, ovf);
endinterface

// File: rtl/fp_to_fixed.sv
// fp_to_fixed: 3-stage IEEE-754 single to signed Q2.30 converter with clock-enable stall.
// Define FP_TO_FIXED_SATURATE_EN to saturate on overflow instead of forcing zero.
module fp_to_fixed (
    input logic        clock,
    input logic        aclr,
    fp_to_fixed_if.slave bus
);
    logic        r_v1, r_s1, r_v2, r_s2, r_ovf2, r_done, r_ovf;
    logic [7:0]  r_e1;
    logic [23:0] r_m1;
    logic [31:0] r_mag2, r_res;
    logic [7:0]  w_rsh;
    logic [31:0] w_mag, w_sat, w_res;
`ifdef FP_TO_FIXED_SATURATE_EN
    logic        r_nan1, r_nan2;
    assign w_sat = (r_s2 && !r_nan2) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    assign w_sat = 32'h0;
`endif
    // e=120 is the unit shift point: Q2.30 value is M * 2^(e-120)
    assign w_rsh = 8'd120 - r_e1;
    assign w_mag = (r_e1 >= 8'd120) ? ({8'd0, r_m1} << (r_e1 - 8'd120))
                 : (w_rsh >= 8'd24) ? 32'd0 : ({8'd0, r_m1} >> w_rsh);
    assign w_res = r_ovf2 ? w_sat : (r_s2 ? -r_mag2 : r_mag2);
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_v1   <= 1'b0;
            r_s1   <= 1'b0;
            r_e1   <= 8'd0;
            r_m1   <= 24'd0;
            r_v2   <= 1'b0;
            r_s2   <= 1'b0;
            r_ovf2 <= 1'b0;
            r_mag2 <= 32'd0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_res  <= 32'd0;
`ifdef FP_TO_FIXED_SATURATE_EN
            r_nan1 <= 1'b0;
            r_nan2 <= 1'b0;
`endif
        end else if (bus.clk_en) begin
            r_v1   <= bus.start;
            r_s1   <= bus.dataa[31];
            r_e1   <= bus.dataa[30:23];
            r_m1   <= (bus.dataa[30:23] == 8'd0) ? 24'd0 : {1'b1, bus.dataa[22:0]};
            r_v2   <= r_v1;
            r_s2   <= r_s1;
            r_ovf2 <= r_e1[7];
            r_mag2 <= w_mag;
            r_done <= r_v2;
`ifdef FP_TO_FIXED_SATURATE_EN
            r_nan1 <= (&bus.dataa[30:23]) && (|bus.dataa[22:0]);
            r_nan2 <= r_nan1;
`endif
            if (r_v2) begin
                r_res <= w_res;
                r_ovf <= r_ovf2;
            end
        end
    end
    assign bus.result = r_res;
    assign bus.done   = r_done;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_fp_to_fixed.sv
// tb_fp_to_fixed: directed self-checking bench for fp_to_fixed
module tb_fp_to_fixed;
    logic clk = 1'b0;
    logic aclr = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    fp_to_fixed_if bus ();
    fp_to_fixed dut (.clock(clk), .aclr(aclr), .bus(bus.slave));
    always #5 clk = ~clk;

`ifdef FP_TO_FIXED_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NV = 15;
    // 2^-24 is 64 LSBs of Q2.30 (e=103, shift 17); shift 24 first appears at e=96
    localparam logic [31:0] DIN [NV] = '{
        32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h8000_0000, 32'h0040_0000,
        32'h3000_0000, 32'h3080_0000, 32'h3380_0000, 32'hBE80_0000, 32'h3FFF_FFFF,
        32'h4000_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'hC000_0000, 32'hFFC0_0000};
    localparam logic [31:0] RES [NV] = '{
        32'h4000_0000, 32'hC000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0001, 32'h0000_0040, 32'hF000_0000, 32'h7FFF_FF80,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic [31:0] RES_SAT [NV] = '{
        32'h4000_0000, 32'hC000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0001, 32'h0000_0040, 32'hF000_0000, 32'h7FFF_FF80,
        32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    localparam logic [NV-1:0] OVF = 15'b111_1100_0000_0000;

    task automatic issue(input logic [31:0] d);
        bus.start = 1'b1;
        bus.dataa = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dataa = 32'hDEAD_BEEF;
    endtask

    // edges after the start edge until done is seen; 20 means it never came
    task automatic wait_done(output int n);
        n = 20;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp += 3;
        if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 00000000", bus.result); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        @(posedge clk); #1;
        aclr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        int n;
        issue(32'h3F06_6B2D);
        wait_done(n);
        n_cmp += 3;
        if (n + 1 !== 3) begin n_bad++; $display("FAIL latency got %0d want 3", n + 1); end
        if (bus.result !== 32'h219A_CB40) begin n_bad++; $display("FAIL lat_result got %h want 219acb40", bus.result); end
        if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL lat_ovf got %b want 0", bus.ovf); end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %b want 0", bus.done); end
    endtask

    task automatic test_vectors;
        int n;
        logic [31:0] exp;
        for (int i = 0; i < NV; i++) begin
            exp = SAT ? RES_SAT[i] : RES[i];
            issue(DIN[i]);
            wait_done(n);
            n_cmp += 3;
            if (n !== 2) begin n_bad++; $display("FAIL vec%0d_latency in %h got %0d want 3", i, DIN[i], n + 1); end
            if (bus.result !== exp) begin n_bad++; $display("FAIL vec%0d_result in %h got %h want %h", i, DIN[i], bus.result, exp); end
            if (bus.ovf !== OVF[i]) begin n_bad++; $display("FAIL vec%0d_ovf in %h got %b want %b", i, DIN[i], bus.ovf, OVF[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F00_0000};
        logic [31:0] r [3] = '{32'h4000_0000, 32'hC000_0000, 32'h2000_0000};
        for (int i = 0; i < 6; i++) begin
            bus.start = (i < 3);
            bus.dataa = (i < 3) ? d[i] : 32'h0;
            @(posedge clk); #1;
            n_cmp++;
            if (i >= 2 && i <= 4) begin
                if (bus.done !== 1'b1 || bus.result !== r[i-2]) begin
                    n_bad++;
                    $display("FAIL b2b_%0d got done=%b result=%h want done=1 result=%h", i - 2, bus.done, bus.result, r[i-2]);
                end
            end else if (bus.done !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_idle_%0d got done=%b want 0", i, bus.done);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_stall;
        int first = 0;
        int pulses = 0;
        issue(32'h3F80_0000);
        bus.clk_en = 1'b0;
        bus.start = 1'b1;
        bus.dataa = 32'h3F00_0000;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                bus.clk_en = 1'b1;
                bus.start = 1'b0;
            end
            if (bus.done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        n_cmp += 3;
        if (first + 1 !== 5) begin n_bad++; $display("FAIL stall_latency got %0d want 5", first + 1); end
        if (pulses !== 1) begin n_bad++; $display("FAIL stall_pulses got %0d want 1", pulses); end
        if (bus.result !== 32'h4000_0000) begin n_bad++; $display("FAIL stall_result got %h want 40000000", bus.result); end
    endtask

    task automatic test_hold;
        bus.dataa = 32'hBF00_0000;
        repeat (4) @(posedge clk);
        #1;
        n_cmp += 3;
        if (bus.result !== 32'h4000_0000) begin n_bad++; $display("FAIL hold_result got %h want 40000000", bus.result); end
        if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL hold_ovf got %b want 0", bus.ovf); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL hold_done got %b want 0", bus.done); end
    endtask

    task automatic test_aclr;
        int n;
        int pulses = 0;
        issue(32'h4000_0000);
        @(posedge clk); #1;
        aclr = 1'b1;
        #1;
        n_cmp += 3;
        if (bus.result !== 32'h0) begin n_bad++; $display("FAIL aclr_result got %h want 00000000", bus.result); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL aclr_done got %b want 0", bus.done); end
        if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL aclr_ovf got %b want 0", bus.ovf); end
        @(posedge clk); #1;
        aclr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_bad++; $display("FAIL aclr_ghost_done got %0d want 0", pulses); end
        issue(32'h3F00_0000);
        wait_done(n);
        n_cmp += 2;
        if (n + 1 !== 3) begin n_bad++; $display("FAIL aclr_restart_latency got %0d want 3", n + 1); end
        if (bus.result !== 32'h2000_0000) begin n_bad++; $display("FAIL aclr_restart_result got %h want 20000000", bus.result); end
    endtask

    task automatic test_first_after_release;
        int n;
        aclr = 1'b1;
        @(posedge clk); #1;
        aclr = 1'b0;
        issue(32'hBF80_0000);
        wait_done(n);
        n_cmp += 2;
        if (n + 1 !== 3) begin n_bad++; $display("FAIL release_latency got %0d want 3", n + 1); end
        if (bus.result !== 32'hC000_0000) begin n_bad++; $display("FAIL release_result got %h want c0000000", bus.result); end
    endtask

    initial begin
        bus.clk_en = 1'b1;
        bus.start = 1'b0;
        bus.dataa = 32'h0;
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_hold();
        test_aclr();
        test_first_after_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
